// File: rtl/proc_pkg.sv
// Shared definitions for the register-file write-port arbiter:
// default widths and the round-robin priority state encoding.
package proc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Records which requester won most recently; the other one wins the next tie.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } prio_e;

endpackage

// File: rtl/mux_5b_2to1.sv
// 2-to-1 multiplexers used on the write-port path: the fixed 5-bit address
// mux and a width-parameterised equivalent for the write data.
module MUX_5B_2to1 (
  input  logic [4:0] d0,
  input  logic [4:0] d1,
  input  logic       sel,
  output logic [4:0] y
);
  assign y = sel ? d1 : d0;
endmodule

module mux_2to1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic         sel,
  output logic [W-1:0] y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. req[0]/gnt[0] is requester A,
// req[1]/gnt[1] is requester B. Grants are combinational; en low blocks all.
module rr_arb2
  import proc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  prio_e state;
  prio_e state_next;

  always_ff @(posedge clk) begin
    if (rst) state <= LAST_B;
    else     state <= state_next;
  end

  // Every grant is a transfer, so the state follows the grant directly.
  always_comb begin
    gnt        = 2'b00;
    state_next = state;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (state == LAST_B) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
      if (gnt[0])      state_next = LAST_A;
      else if (gnt[1]) state_next = LAST_B;
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the ALU (A) and load/multi-cycle (B) paths onto the single
// register-file write port, with one cycle of latency and full throughput.
//
// Handshake: a requester holds valid/addr/data stable until it sees ready;
// a transfer happens on any cycle where valid and ready are both high.
module wb_port_arbiter
  import proc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              stall,
  output logic              grant_sel,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata
);

  logic [1:0]        gnt;
  logic              xfer;
  logic              sel_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_mux;
  logic [DATA_W-1:0] wdata_mux;

  rr_arb2 u_rr_arb2 (
    .clk (clk),
    .rst (rst),
    .req ({b_valid, a_valid}),
    .en  (~stall & ~rst),
    .gnt (gnt)
  );

  assign a_ready   = gnt[0];
  assign b_ready   = gnt[1];
  assign xfer      = |gnt;
  assign grant_sel = xfer ? gnt[1] : sel_q;

  generate
    if (ADDR_W == 5) begin : g_addr_mux5
      MUX_5B_2to1 u_addr_mux (
        .d0  (a_addr),
        .d1  (b_addr),
        .sel (grant_sel),
        .y   (waddr_mux)
      );
    end else begin : g_addr_muxw
      mux_2to1 #(.W(ADDR_W)) u_addr_mux (
        .d0  (a_addr),
        .d1  (b_addr),
        .sel (grant_sel),
        .y   (waddr_mux)
      );
    end
  endgenerate

  mux_2to1 #(.W(DATA_W)) u_data_mux (
    .d0  (a_data),
    .d1  (b_data),
    .sel (grant_sel),
    .y   (wdata_mux)
  );

  // Writes to register 0 are accepted but never enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      sel_q <= grant_sel;
      we_q  <= xfer && (waddr_mux != '0);
      if (xfer) begin
        rf_waddr <= waddr_mux;
        rf_wdata <= wdata_mux;
      end
    end
  end

  // A write registered just before reset rises must not reach the file.
  assign rf_we = we_q & ~rst;

endmodule
